// File: rtl/fpu_chk_pkg.sv
// rtl/fpu_chk_pkg.sv - shared field widths, float classifiers and pipeline pair type
// for fpu_result_checker.
package fpu_chk_pkg;

  localparam int MAX_W    = 64;
  localparam int MAX_CH_W = 4;
  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 52;

  function automatic int exp_width(input int data_w);
    return (data_w == 64) ? DP_EXP_W : SP_EXP_W;
  endfunction

  function automatic int man_width(input int data_w);
    return (data_w == 64) ? DP_MAN_W : SP_MAN_W;
  endfunction

  // Operands arrive zero-extended to MAX_W; the layout is picked by data_w.
  function automatic logic is_nan(input logic [MAX_W-1:0] v, input int data_w);
    logic [MAX_W-1:0] exp_mask;
    logic [MAX_W-1:0] man_mask;
    exp_mask = (MAX_W'(1) << exp_width(data_w)) - MAX_W'(1);
    man_mask = (MAX_W'(1) << man_width(data_w)) - MAX_W'(1);
    return (((v >> man_width(data_w)) & exp_mask) == exp_mask) && ((v & man_mask) != '0);
  endfunction

  function automatic logic is_zero(input logic [MAX_W-1:0] v, input int data_w);
    logic [MAX_W-1:0] mag_mask;
    mag_mask = (MAX_W'(1) << (data_w - 1)) - MAX_W'(1);
    return (v & mag_mask) == '0;
  endfunction

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [MAX_W-1:0]    exp;
    logic [MAX_W-1:0]    act;
    logic                valid;
  } pair_t;

endpackage

// File: rtl/fpu_chk_fifo.sv
// rtl/fpu_chk_fifo.sv - single-clock FIFO with registered full/empty flags and
// wrap-bit pointers.
module fpu_chk_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_next;
  logic [AW:0]       rd_next;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_next = wr_ptr + (AW+1)'(do_push);
  assign rd_next = rd_ptr + (AW+1)'(do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Flags come from the next pointers so a same-cycle push into an empty FIFO
  // only becomes visible one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      empty  <= (wr_next == rd_next);
      full   <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/fpu_result_checker.sv
// rtl/fpu_result_checker.sv - multi-channel expected/actual result checker with a shared
// round-robin comparator; FPU_CHK_ULP_EN adds ULP-tolerant compare.
module fpu_result_checker
  import fpu_chk_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int ULP_TOL = 0,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        exp_valid,
  output logic [NUM_CH-1:0]        exp_ready,
  input  logic [NUM_CH*DATA_W-1:0] exp_data,
  input  logic [NUM_CH-1:0]        act_valid,
  output logic [NUM_CH-1:0]        act_ready,
  input  logic [NUM_CH*DATA_W-1:0] act_data,
  input  logic                     clear,
  output logic [31:0]              match_cnt,
  output logic [31:0]              mismatch_cnt,
  output logic                     err_valid,
  output logic [CH_W-1:0]          err_ch,
  output logic [DATA_W-1:0]        err_exp,
  output logic [DATA_W-1:0]        err_act,
  output logic                     err_sticky,
  output logic                     idle
);

  logic [NUM_CH-1:0] exp_full;
  logic [NUM_CH-1:0] act_full;
  logic [NUM_CH-1:0] exp_empty;
  logic [NUM_CH-1:0] act_empty;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] exp_head [NUM_CH];
  logic [DATA_W-1:0] act_head [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fpu_chk_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_exp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (exp_valid[c]),
      .wdata (exp_data[c*DATA_W +: DATA_W]),
      .full  (exp_full[c]),
      .pop   (pop[c]),
      .rdata (exp_head[c]),
      .empty (exp_empty[c])
    );
    fpu_chk_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_act_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (act_valid[c]),
      .wdata (act_data[c*DATA_W +: DATA_W]),
      .full  (act_full[c]),
      .pop   (pop[c]),
      .rdata (act_head[c]),
      .empty (act_empty[c])
    );
  end

  assign exp_ready = ~exp_full;
  assign act_ready = ~act_full;
  assign eligible  = ~exp_empty & ~act_empty;

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant;
  logic            grant_found;
  int              idx;

  // First eligible channel at or after the pointer, wrapping modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    pop         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && eligible[idx[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant       = idx[CH_W-1:0];
      end
    end
    if (grant_found) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + CH_W'(1);
    end
  end

  pair_t s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= grant_found;
      s1.ch    <= MAX_CH_W'(grant);
      s1.exp   <= MAX_W'(exp_head[grant]);
      s1.act   <= MAX_W'(act_head[grant]);
    end
  end

  logic cmp_match;
`ifdef FPU_CHK_ULP_EN
  logic [DATA_W-2:0] mag_exp;
  logic [DATA_W-2:0] mag_act;
  logic [DATA_W-2:0] mag_diff;
`endif

  always_comb begin
    cmp_match = (s1.exp == s1.act) || (is_nan(s1.exp, DATA_W) && is_nan(s1.act, DATA_W));
`ifdef FPU_CHK_ULP_EN
    mag_exp  = s1.exp[DATA_W-2:0];
    mag_act  = s1.act[DATA_W-2:0];
    mag_diff = (mag_exp >= mag_act) ? (mag_exp - mag_act) : (mag_act - mag_exp);
    if (is_zero(s1.exp, DATA_W) && is_zero(s1.act, DATA_W)) cmp_match = 1'b1;
    if ((s1.exp[DATA_W-1] == s1.act[DATA_W-1]) && !is_nan(s1.exp, DATA_W) &&
        !is_nan(s1.act, DATA_W) && (64'(mag_diff) <= 64'(ULP_TOL))) begin
      cmp_match = 1'b1;
    end
`endif
  end

  logic              s2_valid;
  logic              s2_match;
  logic [CH_W-1:0]   s2_ch;
  logic [DATA_W-1:0] s2_exp;
  logic [DATA_W-1:0] s2_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_match <= 1'b0;
      s2_ch    <= '0;
      s2_exp   <= '0;
      s2_act   <= '0;
    end else begin
      s2_valid <= s1.valid;
      s2_match <= cmp_match;
      s2_ch    <= CH_W'(s1.ch);
      s2_exp   <= s1.exp[DATA_W-1:0];
      s2_act   <= s1.act[DATA_W-1:0];
    end
  end

  // A clear landing on a completed compare discards that pair entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_valid    <= 1'b0;
      err_sticky   <= 1'b0;
      err_ch       <= '0;
      err_exp      <= '0;
      err_act      <= '0;
    end else begin
      err_valid <= 1'b0;
      if (clear) begin
        match_cnt    <= '0;
        mismatch_cnt <= '0;
        err_sticky   <= 1'b0;
      end else if (s2_valid) begin
        if (s2_match) begin
          if (match_cnt != 32'hFFFF_FFFF) match_cnt <= match_cnt + 32'd1;
        end else begin
          if (mismatch_cnt != 32'hFFFF_FFFF) mismatch_cnt <= mismatch_cnt + 32'd1;
          err_valid  <= 1'b1;
          err_sticky <= 1'b1;
          err_ch     <= s2_ch;
          err_exp    <= s2_exp;
          err_act    <= s2_act;
        end
      end
    end
  end

  assign idle = (&exp_empty) & (&act_empty) & ~s1.valid & ~s2_valid;

endmodule

// File: tb/tb_fpu_result_checker.sv
// tb/tb_fpu_result_checker.sv - randomized and directed self-checking bench for
// fpu_result_checker against a queue-based pairing model.
module tb_fpu_result_checker;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int ULP_TOL = 1;
  localparam int NPAIR   = 24;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        exp_valid = '0;
  logic [NUM_CH-1:0]        act_valid = '0;
  logic [NUM_CH-1:0]        exp_ready;
  logic [NUM_CH-1:0]        act_ready;
  logic [NUM_CH*DATA_W-1:0] exp_data = '0;
  logic [NUM_CH*DATA_W-1:0] act_data = '0;
  logic                     clear = 1'b0;
  logic [31:0]              match_cnt;
  logic [31:0]              mismatch_cnt;
  logic                     err_valid;
  logic [1:0]               err_ch;
  logic [31:0]              err_exp;
  logic [31:0]              err_act;
  logic                     err_sticky;
  logic                     idle;

  fpu_result_checker #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ULP_TOL(ULP_TOL)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .clear(clear), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .err_valid(err_valid), .err_ch(err_ch), .err_exp(err_exp), .err_act(err_act),
    .err_sticky(err_sticky), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_exp [NUM_CH][$];
  logic [31:0] q_act [NUM_CH][$];
  logic [63:0] mis_q [NUM_CH][$];
  logic [31:0] m_match = '0;
  logic [31:0] m_mis = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic bit nan32(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic bit ref_match(input logic [31:0] e, input logic [31:0] a);
`ifdef FPU_CHK_ULP_EN
    longint d;
`endif
    if (e == a) return 1'b1;
    if (nan32(e) && nan32(a)) return 1'b1;
`ifdef FPU_CHK_ULP_EN
    if (e[30:0] == 31'd0 && a[30:0] == 31'd0) return 1'b1;
    if (e[31] == a[31] && !nan32(e) && !nan32(a)) begin
      d = longint'(e[30:0]) - longint'(a[30:0]);
      if (d < 0) d = -d;
      if (d <= longint'(ULP_TOL)) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  // Pairs the n-th expected with the n-th actual word of a channel, order-free across channels.
  task automatic model_push(input int c, input bit is_exp, input logic [31:0] v);
    logic [31:0] e;
    logic [31:0] a;
    if (is_exp) q_exp[c].push_back(v);
    else q_act[c].push_back(v);
    while (q_exp[c].size() > 0 && q_act[c].size() > 0) begin
      e = q_exp[c].pop_front();
      a = q_act[c].pop_front();
      if (ref_match(e, a)) begin
        if (m_match != 32'hFFFF_FFFF) m_match++;
      end else begin
        if (m_mis != 32'hFFFF_FFFF) m_mis++;
        mis_q[c].push_back({e, a});
      end
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      q_exp[c].delete();
      q_act[c].delete();
      mis_q[c].delete();
    end
    m_match = '0;
    m_mis = '0;
  endtask

  // Called just after a negedge; returns one cycle later with valids dropped.
  task automatic drive(input logic [NUM_CH-1:0] ev, input logic [NUM_CH-1:0] av,
                       input logic [NUM_CH*DATA_W-1:0] ed, input logic [NUM_CH*DATA_W-1:0] ad);
    exp_valid = ev;
    act_valid = av;
    exp_data  = ed;
    act_data  = ad;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ev[c] && exp_ready[c]) model_push(c, 1'b1, ed[c*DATA_W +: DATA_W]);
      if (av[c] && act_ready[c]) model_push(c, 1'b0, ad[c*DATA_W +: DATA_W]);
    end
    @(negedge clk);
    exp_valid = '0;
    act_valid = '0;
  endtask

  task automatic push1(input int c, input bit de, input bit da, input logic [31:0] e, input logic [31:0] a);
    logic [NUM_CH*DATA_W-1:0] ed;
    logic [NUM_CH*DATA_W-1:0] ad;
    ed = '0;
    ad = '0;
    ed[c*DATA_W +: DATA_W] = e;
    ad[c*DATA_W +: DATA_W] = a;
    drive(de ? NUM_CH'(1) << c : '0, da ? NUM_CH'(1) << c : '0, ed, ad);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!idle && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!idle) check_eq({tag, "_idle_timeout"}, 64'(idle), 64'd1);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_match_cnt"}, 64'(match_cnt), 64'(m_match));
    check_eq({tag, "_mismatch_cnt"}, 64'(mismatch_cnt), 64'(m_mis));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [63:0] p;
    if (!rst && err_valid) begin
      if (mis_q[err_ch].size() == 0) begin
        check_eq("err_unexpected_pulse", 64'(mis_q[err_ch].size()), 64'd1);
      end else begin
        p = mis_q[err_ch].pop_front();
        check_eq("err_exp", 64'(err_exp), 64'(p[63:32]));
        check_eq("err_act", 64'(err_act), 64'(p[31:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] ge [NUM_CH][NPAIR];
  logic [31:0] ga [NUM_CH][NPAIR];

  initial begin
    logic [NUM_CH-1:0]        ev, av;
    logic [NUM_CH*DATA_W-1:0] ed, ad;
    logic [31:0]              base;
    int                       ei [NUM_CH];
    int                       ai [NUM_CH];
    int                       n, total;
    bit                       seen;

    @(negedge clk);
    do_reset();
    check_eq("rst_match_cnt", 64'(match_cnt), 64'd0);
    check_eq("rst_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
    check_eq("rst_err_valid", 64'(err_valid), 64'd0);
    check_eq("rst_err_sticky", 64'(err_sticky), 64'd0);
    check_eq("rst_err_fields", {30'd0, err_ch, err_exp | err_act}, 64'd0);
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_exp_ready", 64'(exp_ready), 64'hF);
    check_eq("rst_act_ready", 64'(act_ready), 64'hF);

    // Single matching pair: three cycles from eligibility to the counter.
    push1(0, 1, 1, 32'h3F80_0000, 32'h3F80_0000);
    check_eq("lat_idle_low", 64'(idle), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("lat_early_cnt", 64'(match_cnt), 64'd0);
    @(negedge clk);
    check_eq("lat_match_cnt", 64'(match_cnt), 64'(m_match));
    check_eq("lat_idle_back", 64'(idle), 64'd1);
    check_eq("lat_no_sticky", 64'(err_sticky), 64'd0);

    push1(0, 1, 1, 32'h4000_0000, 32'h4000_0001);
    wait_idle("ulp");
    check_counts("ulp");
    check_eq("ulp_sticky", 64'(err_sticky), 64'(m_mis != 0));
`ifndef FPU_CHK_ULP_EN
    check_eq("ulp_err_exp_hold", 64'(err_exp), 64'h4000_0000);
`endif

    push1(0, 1, 1, 32'h7FC0_0000, 32'h7F80_0001);
    push1(0, 1, 1, 32'h7F80_0000, 32'h7FC0_0000);
    wait_idle("nan");
    check_counts("nan");

    // All channels eligible together: grants and err_ch walk 0,1,2,3,...
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ad = '0;
      for (int c = 0; c < NUM_CH; c++) ad[c*DATA_W +: DATA_W] = ~(32'h1000_0000 + 32'(c*16 + k));
      drive('0, '1, '0, ad);
    end
    for (int k = 0; k < 3; k++) begin
      ed = '0;
      for (int c = 0; c < NUM_CH; c++) ed[c*DATA_W +: DATA_W] = 32'h1000_0000 + 32'(c*16 + k);
      drive('1, '0, ed, '0);
    end
    n = 0;
    while (!err_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      check_eq("rr_err_valid", 64'(err_valid), 64'd1);
      check_eq("rr_err_ch", 64'(err_ch), 64'(i % NUM_CH));
      @(negedge clk);
    end
    wait_idle("rr");
    check_counts("rr");

    // Fill channel 2 actual FIFO, then release it with expected words.
    for (int k = 0; k < DEPTH + 1; k++) push1(2, 0, 1, '0, $urandom);
    check_eq("full_act_ready2", 64'(act_ready[2]), 64'd0);
    check_eq("full_exp_ready2", 64'(exp_ready[2]), 64'd1);
    push1(2, 1, 0, $urandom, '0);
    check_eq("full_still_full", 64'(act_ready[2]), 64'd0);
    @(negedge clk);
    check_eq("full_ready_back", 64'(act_ready[2]), 64'd1);
    for (int k = 0; k < DEPTH - 1; k++) push1(2, 1, 0, $urandom, '0);
    wait_idle("full");
    check_counts("full");

    // Reset while a mismatching pair is in flight.
    push1(1, 1, 1, 32'h1234_5678, 32'h8765_4321);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (err_valid) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("rstmid_no_err", 64'(seen), 64'd0);
    check_eq("rstmid_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
    check_eq("rstmid_idle", 64'(idle), 64'd1);

    // Randomized traffic with independent valids and backpressure.
    for (int c = 0; c < NUM_CH; c++) begin
      ei[c] = 0;
      ai[c] = 0;
      for (int k = 0; k < NPAIR; k++) begin
        base = $urandom;
        case ($urandom_range(0, 5))
          0: begin ge[c][k] = base; ga[c][k] = base; end
          1: begin ge[c][k] = {base[31], 8'hFF, 1'b1, base[21:0]}; ga[c][k] = {~base[31], 8'hFF, 22'd0, 1'b1}; end
          2: begin ge[c][k] = 32'h7F80_0000; ga[c][k] = 32'h7FC0_0000; end
          3: begin ge[c][k] = {base[31], 8'h40, base[22:0]}; ga[c][k] = {base[31], 8'h40, base[22:0]} + 32'd1; end
          4: begin ge[c][k] = base; ga[c][k] = $urandom; end
          default: begin ge[c][k] = 32'h0000_0000; ga[c][k] = 32'h8000_0000; end
        endcase
      end
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      ev = '0; av = '0; ed = '0; ad = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ei[c] < NPAIR && $urandom_range(0, 3) != 0) begin
          ev[c] = 1'b1;
          ed[c*DATA_W +: DATA_W] = ge[c][ei[c]];
          if (exp_ready[c]) ei[c]++;
        end
        if (ai[c] < NPAIR && $urandom_range(0, 1) != 0) begin
          av[c] = 1'b1;
          ad[c*DATA_W +: DATA_W] = ga[c][ai[c]];
          if (act_ready[c]) ai[c]++;
        end
      end
      drive(ev, av, ed, ad);
    end
    wait_idle("rand");
    total = 0;
    for (int c = 0; c < NUM_CH; c++) total += ei[c] + ai[c];
    check_eq("rand_pushed", 64'(total), 64'(2 * NUM_CH * NPAIR));
    check_counts("rand");
    total = 0;
    for (int c = 0; c < NUM_CH; c++) total += mis_q[c].size();
    check_eq("rand_unreported", 64'(total), 64'd0);

    // Saturation, then clear racing a mismatch in S2.
    force dut.match_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.match_cnt;
    m_match = 32'hFFFF_FFFF;
    push1(3, 1, 1, 32'h3F80_0000, 32'h3F80_0000);
    wait_idle("sat");
    check_eq("sat_match_cnt", 64'(match_cnt), 64'hFFFF_FFFF);
    push1(3, 1, 1, 32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_match = '0;
    m_mis = '0;
    if (mis_q[3].size() > 0) void'(mis_q[3].pop_back());
    check_counts("clear");
    check_eq("clear_sticky", 64'(err_sticky), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_result_checker.md
# fpu_result_checker

Synthesizable, parametrised multi-channel result checker for the FPU environment. It generalises the single-stream compare step of the FPU scoreboard into hardware. It buffers expected results (from the reference model or emulator side) and actual DUT results per channel, and pairs them in order. A single shared comparator is time-shared round-robin across channels; the block keeps match/mismatch statistics and reports each mismatch with its data. It sits beside the FPU DUT in emulation/FPGA builds and in simulation as a fast checker.

## Interface
Parameters:
- NUM_CH, 4, number of independent result channels (1..16)
- DATA_W, 32, operand width; only 32 (single) and 64 (double) are legal
- DEPTH, 8, per-channel FIFO depth, power of two, ≥2
- ULP_TOL, 0, allowed magnitude difference in ULPs (used only under FPU_CHK_ULP_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- exp_valid  in  NUM_CH  expected-result valid, one bit per channel
- exp_ready  out  NUM_CH  expected FIFO not full
- exp_data  in  NUM_CH*DATA_W  expected results; channel c is at [c*DATA_W +: DATA_W]
- act_valid  in  NUM_CH  actual-result valid
- act_ready  out  NUM_CH  actual FIFO not full
- act_data  in  NUM_CH*DATA_W  actual results, same packing as exp_data
- clear  in  1  synchronous clear of counters and sticky flag; does not affect FIFOs
- match_cnt  out  32  saturating count of matched pairs
- mismatch_cnt  out  32  saturating count of mismatched pairs
- err_valid  out  1  single-cycle pulse per mismatch
- err_ch  out  $clog2(NUM_CH) (min 1)  channel of the reported mismatch
- err_exp  out  DATA_W  expected value of the reported mismatch
- err_act  out  DATA_W  actual value of the reported mismatch
- err_sticky  out  1  set on first mismatch, held until rst/clear
- idle  out  1  all FIFOs and pipeline empty

## Operation
- Push: a word is written into a channel's FIFO when valid && ready. Each channel has two FIFOs: expected and actual.
- Eligibility: channel c is eligible when both its expected and actual FIFOs are non-empty.
- Arbiter: a round-robin pointer starts at channel 0. Each cycle the arbiter grants the first eligible channel at or after the pointer, pops one word from both of that channel's FIFOs, and moves the pointer to grant+1 (mod NUM_CH). With no eligible channel, nothing is popped and the pointer holds.
- Pipeline stage S1: registers channel, exp and act, plus a valid bit.
- Pipeline stage S2: compares the registered pair and registers the result. Counters, err_* and err_sticky update from S2.
- Compare rule, exact mode:
  - match iff the bit patterns are equal, or both values are NaN.
  - NaN = exponent all ones and mantissa ≠ 0. Exponent width is 8 for DATA_W 32 and 11 for DATA_W 64.
- Counters saturate at 32'hFFFF_FFFF. clear has priority over a same-cycle increment; that pair is dropped from the statistics.
- err_exp, err_act and err_ch hold their last reported mismatch until the next mismatch. They reset to 0.
- Reset values: match_cnt=0, mismatch_cnt=0, err_valid=0, err_sticky=0, err_*=0, idle=1, exp_ready and act_ready all 1. FIFOs are emptied, the arbiter pointer is set to 0, and the pipeline valid bits are cleared.
- Reset mid-operation discards in-flight pairs with no err_valid pulse.

## Timing
- Latency from the cycle a channel becomes eligible to the counter/err_valid update is 3 cycles (arbitrate+pop, S1, S2).
- Throughput is one compared pair per cycle across all channels.
- FIFO flags are registered:
  - A push to a full FIFO is impossible because ready is low.
  - Push and pop in the same cycle on a full FIFO is not accepted: ready is already low.
  - Push and pop in the same cycle on an empty FIFO does not make the entry poppable that cycle; it becomes eligible next cycle.
- FIFO pointers are log2(DEPTH)+1 bits wide, with full/empty derived from wrap-bit comparison.
- idle deasserts the cycle after any push and reasserts the cycle after the final S2 update.

## Configuration
- FPU_CHK_ULP_EN, when defined, enables tolerance compare. A pair also matches when:
  - the signs are equal, neither value is NaN, and |exp[DATA_W-2:0] − act[DATA_W-2:0]| ≤ ULP_TOL (unsigned magnitude difference); or
  - both values are zero of any sign.
- When FPU_CHK_ULP_EN is undefined, only the exact rule applies, ULP_TOL is ignored, and no subtractor is built.

## Structure
- fpu_chk_pkg holds:
  - exponent/mantissa width localparams selected by DATA_W;
  - the is_nan/is_zero functions;
  - the pair struct {ch, exp, act, valid}.
- Sub-module fpu_chk_fifo: single-clock FIFO with DEPTH/DATA_W parameters, registered full/empty. It is instantiated 2×NUM_CH times.
- The top level holds the arbiter, the S1/S2 pipeline, the comparator and the counters.

## Test plan
- NUM_CH=1, push exp 32'h3F80_0000 and act 32'h3F80_0000 → match_cnt=1 three cycles after eligibility, err_valid never asserts.
- exp 32'h4000_0000, act 32'h4000_0001 with ULP_TOL=1:
  - macro undefined → mismatch_cnt=1, err_valid pulse with err_exp=32'h4000_0000, err_act=32'h4000_0001, err_sticky=1;
  - macro defined → match_cnt=1.
- exp 32'h7FC0_0000, act 32'h7F80_0001 (both NaN) → match; exp 32'h7F80_0000 (+Inf) vs act 32'h7FC0_0000 → mismatch.
- NUM_CH=4, all channels eligible continuously → grants cycle 0,1,2,3,0,…; one pair per cycle; err_ch follows the same order for forced mismatches.
- Fill channel 2 actual FIFO with DEPTH words and no expected → act_ready[2]=0. Then push one expected → one pop, act_ready[2]=1 next cycle, no data loss.
- Preload match_cnt to saturation via force, one more match → match_cnt stays 32'hFFFF_FFFF. clear together with an S2 mismatch → counters 0, err_sticky=0.
